// File: rtl/jtopl_mmr2.sv
// jtopl_mmr2: CPU register front-end decoding index/data writes into timer, global and operator/channel strobes
module jtopl_mmr2 #(
  parameter int BANKS    = 1,
  parameter int BUSY_CYC = 12
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cenop,
  input  logic [7:0] din,
  input  logic       write,
  input  logic [1:0] addr,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic       busy,
  output logic [7:0] din_copy,
  output logic [7:0] latch_fnum,
  output logic       sel_bank,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnum,
  output logic       up_fbcon,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flag,
  output logic       csm,
  output logic       nts,
  output logic       new_mode
);
  logic [7:0] selreg, cnt;
  logic       selbank, drop, acc, bank_in, op_hit, ch_hit, glob0;
  logic [1:0] ch_grp;
  logic [3:0] ch_sub4;
  assign busy    = cnt != 8'd0;
  assign acc     = write & addr[0] & ~busy;
  assign bank_in = (BANKS == 2) ? addr[1] : 1'b0;
  assign glob0   = acc & ~selbank;
  assign op_hit  = selreg[7:5] >= 3'd1 && selreg[7:5] <= 3'd4 && selreg[2:0] <= 3'd5 && selreg[4:3] != 2'd3;
  assign ch_hit  = selreg[7:4] >= 4'hA && selreg[7:4] <= 4'hC && selreg[3:0] <= 4'd8;
  assign ch_grp  = selreg[3:0] >= 4'd6 ? 2'd2 : selreg[3:0] >= 4'd3 ? 2'd1 : 2'd0;
  assign ch_sub4 = selreg[3:0] - {1'b0, ch_grp, 1'b0} - {2'b0, ch_grp};
  // strobes hold until the first cenop after being set; a fresh set beats the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      selreg <= 8'd0; selbank <= 1'b0; cnt <= 8'd0; drop <= 1'b0; dout <= 8'd0;
      din_copy <= 8'd0; latch_fnum <= 8'd0; sel_bank <= 1'b0; sel_group <= 2'd0; sel_sub <= 3'd0;
      up_mult <= 1'b0; up_ksl_tl <= 1'b0; up_ar_dr <= 1'b0; up_sl_rr <= 1'b0; up_fnum <= 1'b0; up_fbcon <= 1'b0;
      value_A <= 8'd0; value_B <= 8'd0; load_A <= 1'b0; load_B <= 1'b0;
      flagen_A <= 1'b1; flagen_B <= 1'b1; clr_flag <= 1'b0; csm <= 1'b0; nts <= 1'b0; new_mode <= 1'b0;
    end else begin
      if (write & ~addr[0]) begin
        selreg  <= din;
        selbank <= bank_in;
      end
      cnt <= acc ? 8'(BUSY_CYC) : (cenop && busy) ? cnt - 8'd1 : cnt;
      if (write & addr[0] & busy) drop <= 1'b1;
      else if (glob0 && selreg == 8'h04 && din[7]) drop <= 1'b0;
      if (acc) din_copy <= din;
      if (acc & (op_hit | ch_hit)) begin
        sel_bank  <= selbank;
        sel_group <= op_hit ? selreg[4:3] : ch_grp;
        sel_sub   <= op_hit ? selreg[2:0] : ch_sub4[2:0];
      end
      if (acc && ch_hit && selreg[7:4] == 4'hA) latch_fnum <= din;
      up_mult   <= (acc && op_hit && selreg[7:5] == 3'd1) | (up_mult & ~cenop);
      up_ksl_tl <= (acc && op_hit && selreg[7:5] == 3'd2) | (up_ksl_tl & ~cenop);
      up_ar_dr  <= (acc && op_hit && selreg[7:5] == 3'd3) | (up_ar_dr & ~cenop);
      up_sl_rr  <= (acc && op_hit && selreg[7:5] == 3'd4) | (up_sl_rr & ~cenop);
      up_fnum   <= (acc && ch_hit && selreg[7:4] == 4'hB) | (up_fnum & ~cenop);
      up_fbcon  <= (acc && ch_hit && selreg[7:4] == 4'hC) | (up_fbcon & ~cenop);
      if (glob0 && selreg == 8'h02) value_A <= din;
      if (glob0 && selreg == 8'h03) value_B <= din;
      if (glob0 && selreg == 8'h04) begin
        flagen_A <= ~din[6];
        flagen_B <= ~din[5];
        {load_B, load_A} <= din[1:0];
      end
      clr_flag <= (glob0 && selreg == 8'h04) ? din[7] : clr_flag & ~cenop;
      if (glob0 && selreg == 8'h08) begin
        csm <= din[7];
        nts <= din[6];
      end
      if (BANKS == 2 && acc && selbank && selreg == 8'h05) new_mode <= din[0];
      dout <= {(flag_A & flagen_A) | (flag_B & flagen_B), flag_A, flag_B, 4'd0, drop};
    end
  end
endmodule

// File: tb/tb_jtopl_mmr2.sv
// tb_jtopl_mmr2: directed vector table plus hand sequences for busy, drop, strobe hold and status
module tb_jtopl_mmr2;
  logic rst = 1'b1, clk = 1'b0, cenop = 1'b0, write = 1'b0, flag_A = 1'b0, flag_B = 1'b0;
  logic [7:0] din = 8'd0;
  logic [1:0] addr = 2'd0;
  logic [7:0] dout, din_copy, latch_fnum, value_A, value_B;
  logic busy, sel_bank, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon;
  logic load_A, load_B, flagen_A, flagen_B, clr_flag, csm, nts, new_mode;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  int passed = 0, total = 0;

  jtopl_mmr2 #(.BANKS(2), .BUSY_CYC(12)) dut (
    .rst(rst), .clk(clk), .cenop(cenop), .din(din), .write(write), .addr(addr), .dout(dout),
    .flag_A(flag_A), .flag_B(flag_B), .busy(busy), .din_copy(din_copy), .latch_fnum(latch_fnum),
    .sel_bank(sel_bank), .sel_group(sel_group), .sel_sub(sel_sub), .up_mult(up_mult),
    .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr), .up_fnum(up_fnum),
    .up_fbcon(up_fbcon), .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag(clr_flag), .csm(csm), .nts(nts),
    .new_mode(new_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic [7:0] idx;
    logic [7:0] dat;
    logic [5:0] strb;
    logic [1:0] grp;
    logic [2:0] sub;
    logic       sb;
  } vec_t;
  vec_t v[11];

  task automatic cyc(input logic w, input logic [1:0] a, input logic [7:0] d, input logic ce);
    @(negedge clk);
    write = w; addr = a; din = d; cenop = ce;
    @(posedge clk);
    #1;
    write = 1'b0; cenop = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && busy; i++) cyc(1'b0, 2'd0, 8'd0, 1'b1);
    chk("busy_end", 16'(busy), 16'd0);
  endtask

  task automatic wr(input logic b, input logic [7:0] idx, input logic [7:0] dat);
    cyc(1'b1, {b, 1'b0}, idx, 1'b0);
    cyc(1'b1, {b, 1'b1}, dat, 1'b0);
  endtask

  function automatic logic [5:0] strobes();
    return {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon};
  endfunction

  initial begin
    v[0]  = '{1'b0, 8'h20, 8'h11, 6'b100000, 2'd0, 3'd0, 1'b0};
    v[1]  = '{1'b0, 8'h43, 8'h3F, 6'b010000, 2'd0, 3'd3, 1'b0};
    v[2]  = '{1'b0, 8'h6D, 8'h12, 6'b001000, 2'd1, 3'd5, 1'b0};
    v[3]  = '{1'b0, 8'h92, 8'h34, 6'b000100, 2'd2, 3'd2, 1'b0};
    v[4]  = '{1'b0, 8'h26, 8'h56, 6'b000000, 2'd2, 3'd2, 1'b0};
    v[5]  = '{1'b0, 8'h38, 8'h78, 6'b000000, 2'd2, 3'd2, 1'b0};
    v[6]  = '{1'b1, 8'hB7, 8'h31, 6'b000010, 2'd2, 3'd1, 1'b1};
    v[7]  = '{1'b0, 8'hC4, 8'h9A, 6'b000001, 2'd1, 3'd1, 1'b0};
    v[8]  = '{1'b0, 8'hA8, 8'h77, 6'b000000, 2'd2, 3'd2, 1'b0};
    v[9]  = '{1'b0, 8'hB9, 8'hBC, 6'b000000, 2'd2, 3'd2, 1'b0};
    v[10] = '{1'b1, 8'h20, 8'hDE, 6'b100000, 2'd0, 3'd0, 1'b1};
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    rst = 1'b0;
    chk("rst_dout", 16'(dout), 16'h00);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_flagen", 16'({flagen_A, flagen_B}), 16'h3);
    chk("rst_strobes", 16'(strobes()), 16'd0);
    chk("rst_new_mode", 16'(new_mode), 16'd0);
    // busy window counts exactly 12 cenops
    wr(1'b0, 8'h02, 8'h5A);
    chk("value_A", 16'(value_A), 16'h5A);
    chk("busy_rise", 16'(busy), 16'd1);
    for (int i = 0; i < 11; i++) cyc(1'b0, 2'd0, 8'd0, 1'b1);
    chk("busy_11", 16'(busy), 16'd1);
    cyc(1'b0, 2'd0, 8'd0, 1'b1);
    chk("busy_12", 16'(busy), 16'd0);
    // strobe hold, dropped write, drop clear via 0x04
    wr(1'b0, 8'h43, 8'h3F);
    chk("ksl_set", 16'(up_ksl_tl), 16'd1);
    chk("ksl_grp_sub", 16'({sel_group, sel_sub}), 16'({2'd0, 3'd3}));
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    chk("ksl_hold", 16'(up_ksl_tl), 16'd1);
    cyc(1'b1, 2'b01, 8'h55, 1'b0);
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    chk("drop_dout", 16'(dout), 16'h01);
    chk("drop_din_copy", 16'(din_copy), 16'h3F);
    cyc(1'b0, 2'd0, 8'd0, 1'b1);
    chk("ksl_clear", 16'(up_ksl_tl), 16'd0);
    wait_busy();
    wr(1'b0, 8'h04, 8'h80);
    chk("clr_flag_set", 16'(clr_flag), 16'd1);
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    chk("drop_cleared", 16'(dout), 16'h00);
    chk("clr_flag_hold", 16'(clr_flag), 16'd1);
    cyc(1'b0, 2'd0, 8'd0, 1'b1);
    chk("clr_flag_clear", 16'(clr_flag), 16'd0);
    wait_busy();
    // accepted write coincident with cenop: set wins, busy still loads
    cyc(1'b1, 2'b00, 8'h20, 1'b0);
    cyc(1'b1, 2'b01, 8'h01, 1'b1);
    chk("same_clk_set", 16'(up_mult), 16'd1);
    chk("same_clk_busy", 16'(busy), 16'd1);
    cyc(1'b0, 2'd0, 8'd0, 1'b1);
    chk("same_clk_clear", 16'(up_mult), 16'd0);
    wait_busy();
    for (int i = 0; i < 11; i++) begin
      wr(v[i].b, v[i].idx, v[i].dat);
      chk($sformatf("v%0d_strb", i), 16'(strobes()), 16'(v[i].strb));
      chk($sformatf("v%0d_grp_sub", i), 16'({sel_group, sel_sub}), 16'({v[i].grp, v[i].sub}));
      chk($sformatf("v%0d_bank", i), 16'(sel_bank), 16'(v[i].sb));
      chk($sformatf("v%0d_din_copy", i), 16'(din_copy), 16'(v[i].dat));
      wait_busy();
      chk($sformatf("v%0d_strb_clr", i), 16'(strobes()), 16'd0);
    end
    chk("latch_fnum", 16'(latch_fnum), 16'h77);
    // bank-1 new_mode, bank-0 same address ignored
    wr(1'b1, 8'h05, 8'h01);
    chk("new_mode_set", 16'(new_mode), 16'd1);
    wait_busy();
    wr(1'b0, 8'h05, 8'h00);
    chk("new_mode_bank0", 16'(new_mode), 16'd1);
    wait_busy();
    wr(1'b0, 8'h08, 8'hC0);
    chk("csm_nts", 16'({csm, nts}), 16'h3);
    wait_busy();
    wr(1'b1, 8'h03, 8'h99);
    chk("value_B_bank1", 16'(value_B), 16'h00);
    wait_busy();
    // status register
    flag_A = 1'b1;
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    chk("dout_irq", 16'(dout), 16'hC0);
    wr(1'b0, 8'h04, 8'h43);
    chk("flagen_A_off", 16'(flagen_A), 16'd0);
    chk("loads", 16'({load_B, load_A}), 16'h3);
    cyc(1'b0, 2'd0, 8'd0, 1'b0);
    chk("dout_noirq", 16'(dout), 16'h40);
    wait_busy();
    // reset in the middle of a busy window
    flag_A = 1'b0;
    wr(1'b0, 8'h20, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_busy", 16'(busy), 16'd0);
    chk("rst_mid_strobe", 16'(up_mult), 16'd0);
    chk("rst_mid_flagen", 16'({flagen_A, flagen_B}), 16'h3);
    chk("rst_mid_new_mode", 16'(new_mode), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
